// File: rtl/reg_bus_arb_pkg.sv
`default_nettype none
// =============================================================================
// Module  : reg_bus_arb_pkg
// Brief   : Shared types and helpers for the register-bus round-robin arbiter.
// Revision: 1.0
// =============================================================================
package reg_bus_arb_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;
   localparam int unsigned DEFAULT_ADDR_WIDTH     = 32;
   localparam int unsigned DEFAULT_DATA_WIDTH     = 32;

   typedef struct packed {
      logic                                valid;
      logic [DEFAULT_ADDR_WIDTH-1:0]       addr;
      logic                                write;
      logic [DEFAULT_DATA_WIDTH-1:0]       wdata;
      logic [DEFAULT_DATA_WIDTH/8-1:0]     wstrb;
   } reg_bus_req_t;

   typedef struct packed {
      logic                                ready;
      logic [DEFAULT_DATA_WIDTH-1:0]       rdata;
      logic                                error;
   } reg_bus_rsp_t;

   // A single port still needs a 1-bit index signal.
   function automatic int unsigned idx_width(input int unsigned num_ports);
      return (num_ports > 1) ? int'($clog2(num_ports)) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/reg_bus_arb_pick.sv
`default_nettype none
// =============================================================================
// Module  : reg_bus_arb_pick
// Brief   : Combinational round-robin picker: first valid port from ptr upwards.
// Revision: 1.0
// =============================================================================
module reg_bus_arb_pick
   import reg_bus_arb_pkg::*;
#(
   parameter int unsigned NumPorts = 4,
   parameter int unsigned IdxWidth = idx_width(NumPorts)
) (
   input  logic [NumPorts-1:0] valid_i,
   input  logic [IdxWidth-1:0] ptr_i,
   output logic [IdxWidth-1:0] idx_o,
   output logic                any_valid_o
);

   function automatic logic [IdxWidth-1:0] wrap_add(input logic [IdxWidth-1:0] base,
                                                    input int unsigned        off);
      return IdxWidth'((32'(base) + off) % NumPorts);
   endfunction

   // Scan farthest offset first so the nearest valid port is the last write.
   always_comb begin
      idx_o = '0;
      for (int off = NumPorts - 1; off >= 0; off--) begin
         if (valid_i[wrap_add(ptr_i, unsigned'(off))]) begin
            idx_o = wrap_add(ptr_i, unsigned'(off));
         end
      end
   end

   assign any_valid_o = |valid_i;

endmodule
`default_nettype wire

// File: rtl/reg_bus_rr_arbiter.sv
`default_nettype none
// =============================================================================
// Module  : reg_bus_rr_arbiter
// Brief   : Round-robin, lock-until-complete sharing of one register-bus target.
//           Watchdog enabled by defining REG_BUS_RR_ARBITER_TIMEOUT_EN.
// Revision: 1.0
// =============================================================================
module reg_bus_rr_arbiter
   import reg_bus_arb_pkg::*;
#(
   parameter int unsigned NumPorts      = 4,
   parameter int unsigned AddrWidth     = DEFAULT_ADDR_WIDTH,
   parameter int unsigned DataWidth     = DEFAULT_DATA_WIDTH,
   parameter int unsigned TimeoutCycles = DEFAULT_TIMEOUT_CYCLES,
   parameter type         reg_req_t     = reg_bus_req_t,
   parameter type         reg_rsp_t     = reg_bus_rsp_t,
   parameter int unsigned IdxWidth      = idx_width(NumPorts)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  reg_req_t            in_req_i [NumPorts],
   output reg_rsp_t            in_rsp_o [NumPorts],
   output reg_req_t            out_req_o,
   input  reg_rsp_t            out_rsp_i,
   output logic [IdxWidth-1:0] gnt_idx_o,
   output logic                busy_o,
   output logic                timeout_o
);

   if (NumPorts < 1 || TimeoutCycles < 2 ||
       $bits(reg_req_t) != AddrWidth + DataWidth + DataWidth/8 + 2 ||
       $bits(reg_rsp_t) != DataWidth + 2) begin : g_param_check
      $error("reg_bus_rr_arbiter: inconsistent parameters");
   end

   arb_state_e          state_q, state_d;
   logic [IdxWidth-1:0] gnt_idx_q, gnt_idx_d;
   logic [IdxWidth-1:0] ptr_q, ptr_d;
   logic [IdxWidth-1:0] next_ptr;
   logic [IdxWidth-1:0] pick_idx;
   logic                pick_any;
   logic [NumPorts-1:0] req_valid;

`ifdef REG_BUS_RR_ARBITER_TIMEOUT_EN
   localparam int unsigned CntWidth = $clog2(TimeoutCycles);
   logic [CntWidth-1:0] wdog_cnt_q, wdog_cnt_d;
`endif

   always_comb begin
      for (int k = 0; k < NumPorts; k++) begin
         req_valid[k] = in_req_i[k].valid;
      end
   end

   reg_bus_arb_pick #(
      .NumPorts (NumPorts),
      .IdxWidth (IdxWidth)
   ) u_pick (
      .valid_i     (req_valid),
      .ptr_i       (ptr_q),
      .idx_o       (pick_idx),
      .any_valid_o (pick_any)
   );

   assign next_ptr  = (gnt_idx_q == IdxWidth'(NumPorts - 1)) ? '0 : gnt_idx_q + IdxWidth'(1);
   assign gnt_idx_o = gnt_idx_q;
   assign busy_o    = (state_q == BUSY);

   always_comb begin
      state_d   = state_q;
      gnt_idx_d = gnt_idx_q;
      ptr_d     = ptr_q;
      out_req_o = '0;
      timeout_o = 1'b0;
      for (int k = 0; k < NumPorts; k++) begin
         in_rsp_o[k] = '0;
      end
`ifdef REG_BUS_RR_ARBITER_TIMEOUT_EN
      wdog_cnt_d = wdog_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               gnt_idx_d = pick_idx;
               state_d   = BUSY;
`ifdef REG_BUS_RR_ARBITER_TIMEOUT_EN
               wdog_cnt_d = '0;
`endif
            end
         end
         BUSY: begin
            out_req_o           = in_req_i[gnt_idx_q];
            in_rsp_o[gnt_idx_q] = out_rsp_i;
            if (out_rsp_i.ready) begin
               state_d = IDLE;
               ptr_d   = next_ptr;
            end
`ifdef REG_BUS_RR_ARBITER_TIMEOUT_EN
            // A real ready on the expiry cycle wins; otherwise answer with an error.
            else if (wdog_cnt_q == CntWidth'(TimeoutCycles - 1)) begin
               in_rsp_o[gnt_idx_q]       = '0;
               in_rsp_o[gnt_idx_q].ready = 1'b1;
               in_rsp_o[gnt_idx_q].error = 1'b1;
               timeout_o                 = 1'b1;
               state_d                   = IDLE;
               ptr_d                     = next_ptr;
            end else begin
               wdog_cnt_d = wdog_cnt_q + CntWidth'(1);
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         gnt_idx_q <= '0;
         ptr_q     <= '0;
`ifdef REG_BUS_RR_ARBITER_TIMEOUT_EN
         wdog_cnt_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         gnt_idx_q <= gnt_idx_d;
         ptr_q     <= ptr_d;
`ifdef REG_BUS_RR_ARBITER_TIMEOUT_EN
         wdog_cnt_q <= wdog_cnt_d;
`endif
      end
   end

`ifndef SYNTHESIS
   logic [NumPorts-1:0] rsp_ready;

   always_comb begin
      for (int k = 0; k < NumPorts; k++) begin
         rsp_ready[k] = in_rsp_o[k].ready;
      end
   end

   a_out_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      out_req_o.valid && !out_rsp_i.ready && !timeout_o |=> $stable(out_req_o));

   a_one_ready: assert property (@(posedge clk_i) $onehot0(rsp_ready));

   a_granted_holds_valid: assert property (@(posedge clk_i) disable iff (rst_i)
      busy_o |-> in_req_i[gnt_idx_q].valid);
`endif

endmodule
`default_nettype wire
